// File: rtl/fc_pkg.sv
// Shared constants and FSM state type for the FC scheduler slice.
//   DATA_W    : default signed data/weight/result width
//   VEC_LEN   : default elements per FC input vector
//   BIAS_ADDR : cfg address of the bias register (one past the last weight)
package fc_pkg;
    localparam int DATA_W    = 32;
    localparam int VEC_LEN   = 9;
    localparam int BIAS_ADDR = VEC_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } fc_state_t;
endpackage

// File: rtl/relu_unit.sv
// Rectifier: passes x when strictly positive, otherwise zero.
//   x : signed two's-complement input
//   y : relu(x)
module relu_unit #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    // Zero passes through unchanged, so only the sign bit matters.
    assign y = x[W-1] ? '0 : x;
endmodule

// File: rtl/fc_scheduler.sv
// Round-robin scheduler sharing one multiply-accumulate FC engine among
// NUM_CORES requesters. A granted core streams VEC_LEN elements which are
// dotted with the weight vector; bias is added, ReLU'd and presented with
// a valid/ready handshake together with the owning core index.
//   clk, rst            : clock, async active-high reset
//   req / gnt           : per-core request, one-hot registered grant
//   in_valid/in_data    : per-core element stream (core i at [i*DATA_W +: DATA_W])
//   in_ready            : element accept, only for the granted core in ACCUM
//   cfg_we/addr/wdata   : weight (addr < VEC_LEN) and bias (addr == VEC_LEN) writes, IDLE only
//   out_valid/data/id   : result, held until out_ready
module fc_scheduler #(
    parameter int  NUM_CORES = 4,
    parameter int  VEC_LEN   = fc_pkg::VEC_LEN,
    parameter int  DATA_W    = fc_pkg::DATA_W,
    localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    output logic [NUM_CORES-1:0]          gnt,
    input  logic [NUM_CORES-1:0]          in_valid,
    input  logic [NUM_CORES*DATA_W-1:0]   in_data,
    output logic [NUM_CORES-1:0]          in_ready,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [DATA_W-1:0]             cfg_wdata,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [ID_W-1:0]               out_id,
    input  logic                          out_ready
);
    localparam int             CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    fc_pkg::fc_state_t state_q, state_d;

    logic [NUM_CORES-1:0][DATA_W-1:0] in_vec;
    logic [VEC_LEN-1:0][DATA_W-1:0]   w;
    logic [DATA_W-1:0]                bias, acc, prod, acc_nxt, biased, relu_y;
    logic [CNT_W-1:0]                 cnt;
    logic [ID_W-1:0]                  g_idx, rr_ptr, pick, pick_nxt;
    logic [ID_W:0]                    cand;
    logic                             pick_vld, accept;

    assign in_vec = in_data;

    // Round-robin search starting at rr_ptr (one past the last grant).
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_CORES))
                cand = cand - (ID_W+1)'(NUM_CORES);
            if (!pick_vld && req[cand[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[ID_W-1:0];
            end
        end
    end
    assign pick_nxt = (pick == ID_W'(NUM_CORES - 1)) ? '0 : pick + ID_W'(1);

    // Products and sums are kept to DATA_W bits: wrap-around arithmetic.
    assign accept  = (state_q == fc_pkg::ACCUM) && in_valid[g_idx];
    assign prod    = in_vec[g_idx] * w[cnt];
    assign acc_nxt = acc + prod;
    assign biased  = acc_nxt + bias;

    relu_unit #(.W(DATA_W)) u_relu (.x(biased), .y(relu_y));

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_rdy
        assign in_ready[i] = (state_q == fc_pkg::ACCUM) && gnt[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= fc_pkg::IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            fc_pkg::IDLE:  if (pick_vld)                  state_d = fc_pkg::ACCUM;
            fc_pkg::ACCUM: if (accept && cnt == LAST)     state_d = fc_pkg::OUT;
            fc_pkg::OUT:   if (out_ready)                 state_d = fc_pkg::IDLE;
            default:                                      state_d = fc_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            bias      <= '0;
            for (int k = 0; k < VEC_LEN; k++) w[k] <= DATA_W'(1);
        end else begin
            case (state_q)
                fc_pkg::IDLE: begin
                    // Weight write lands on the same edge as a grant, so the
                    // first element already sees the new value.
                    if (cfg_we) begin
                        for (int k = 0; k < VEC_LEN; k++)
                            if (cfg_addr == 4'(k)) w[k] <= cfg_wdata;
                        if (cfg_addr == 4'(VEC_LEN)) bias <= cfg_wdata;
                    end
                    if (pick_vld) begin
                        gnt    <= NUM_CORES'(1) << pick;
                        g_idx  <= pick;
                        rr_ptr <= pick_nxt;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                fc_pkg::ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            out_valid <= 1'b1;
                            out_data  <= relu_y;
                            out_id    <= g_idx;
                        end
                    end
                end
                fc_pkg::OUT: begin
                    // Grant stays up through OUT regardless of req.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_scheduler.sv
module tb_fc_scheduler;
    localparam int NC = 4, VL = 9, DW = 32, IW = 2;

    logic          clk = 1'b0, rst = 1'b1;
    logic [NC-1:0] req = '0, gnt, in_valid = '0, in_ready;
    logic [NC*DW-1:0] in_data = '0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;

    always #5 clk = ~clk;

    fc_scheduler #(.NUM_CORES(NC), .VEC_LEN(VL), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .out_valid(out_valid),
        .out_data(out_data), .out_id(out_id), .out_ready(out_ready));

    int n_tests = 0, n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // The scheduler is "busy" with core mg (or free, mg<0); while busy it
    // collects elements into a list; once VL are in, the result is the
    // ReLU of the dot product plus bias and is owed until out_ready.
    logic [DW-1:0] mw [VL];
    logic [DW-1:0] mbias, mres;
    logic [DW-1:0] elems [$];
    int            mg, mstart;
    int            grant_log [$];
    logic [NC-1:0] prev_gnt, eg, er;

    function automatic int rr_pick(logic [NC-1:0] r, int start);
        for (int i = 0; i < NC; i++)
            if (r[(start + i) % NC]) return (start + i) % NC;
        return -1;
    endfunction

    function automatic logic [DW-1:0] model_result();
        logic [DW-1:0] s;
        s = mbias;
        for (int k = 0; k < VL; k++) s = s + elems[k] * mw[k];
        return ($signed(s) > 0) ? s : '0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < VL; k++) mw[k] = 1;
            mbias = 0; mg = -1; mstart = 0; elems.delete();
            chk("rst_gnt", gnt, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_id", out_id, 0);
        end else begin
            eg = (mg < 0) ? '0 : NC'(1) << mg;
            er = (mg >= 0 && elems.size() < VL) ? eg : '0;
            chk("gnt", gnt, eg);
            chk("in_ready", in_ready, er);
            chk("out_valid", out_valid, (mg >= 0 && elems.size() == VL));
            if (mg >= 0 && elems.size() == VL) begin
                chk("out_data", out_data, mres);
                chk("out_id", out_id, mg);
            end
            if (gnt != 0 && prev_gnt == 0)
                for (int i = 0; i < NC; i++) if (gnt[i]) grant_log.push_back(i);
            // advance to what the next rising edge must produce
            if (mg < 0) begin
                if (cfg_we) begin
                    if (cfg_addr < VL) mw[cfg_addr] = cfg_wdata;
                    else if (cfg_addr == VL) mbias = cfg_wdata;
                end
                if (req != 0) begin
                    mg = rr_pick(req, mstart);
                    mstart = (mg + 1) % NC;
                    elems.delete();
                end
            end else if (elems.size() < VL) begin
                if (in_valid[mg]) begin
                    elems.push_back(in_data[mg*DW +: DW]);
                    if (elems.size() == VL) mres = model_result();
                end
            end else if (out_ready) begin
                mg = -1;
            end
        end
        prev_gnt = gnt;
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] src [NC][$];
    bit            gaps = 1'b0;
    bit [NC-1:0]   fire;
    int            acc_cnt [NC];

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NC; i++) fire[i] = in_valid[i] && in_ready[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (fire[i] && src[i].size() > 0) begin
                void'(src[i].pop_front());
                acc_cnt[i]++;
            end
            in_valid[i] = (src[i].size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
            in_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : $urandom;
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NC; i++) src[i].delete();
    endtask

    task automatic load_seq(int c, int first, int inc);
        for (int k = 0; k < VL; k++) src[c].push_back(DW'(first + k * inc));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; clear_src();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(int c, int max);
        bit ok;
        ok = gnt[c];
        for (int n = 0; n < max && !ok; n++) begin step(); ok = gnt[c]; end
        if (!ok) chk("timeout_gnt", 0, 1);
    endtask

    task automatic wait_out(int max);
        bit ok;
        ok = out_valid;
        for (int n = 0; n < max && !ok; n++) begin step(); ok = out_valid; end
        if (!ok) chk("timeout_out", 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("post_hs_gnt", gnt, 0);
        chk("post_hs_valid", out_valid, 0);
    endtask

    task automatic cfg(int a, logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        do_reset();

        // core0 sends 1..9 with default weights -> 45
        load_seq(0, 1, 1); req = 4'b0001;
        wait_gnt(0, 10); req = '0;            // grant must survive req dropping
        wait_out(40);
        chk("t1_data", out_data, 45);
        chk("t1_id", out_id, 0);
        handshake();

        // all weights -1, bias 5, nine 1s from core1 -> relu(-4) = 0
        for (int k = 0; k < VL; k++) cfg(k, '1);
        cfg(VL, 5);
        load_seq(1, 1, 0); req = 4'b0010;
        wait_gnt(1, 10); req = '0;
        wait_out(40);
        chk("t2_model_pin", mres, 0);
        chk("t2_data", out_data, 0);
        chk("t2_id", out_id, 1);
        handshake();

        // all cores requesting -> 0,1,2,3,0
        do_reset();
        grant_log.delete();
        req = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 300 && grant_log.size() < 5; n++) begin
            for (int i = 0; i < NC; i++)
                if (src[i].size() == 0) load_seq(i, $urandom_range(0, 50), 3);
            step();
        end
        req = '0;
        for (int n = 0; n < 40 && gnt != 0; n++) step();
        out_ready = 1'b0;
        chk("t3_grants", grant_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk($sformatf("t3_order%0d", k), grant_log[k], k % NC);

        // held output while out_ready low; competing request must wait
        clear_src(); step();
        load_seq(2, 7, -4); req = 4'b0100;
        wait_gnt(2, 10); req = 4'b1100;
        wait_out(40);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, mres);
            chk("t4_hold_id", out_id, 2);
            chk("t4_hold_gnt", gnt, 4'b0100);
        end
        req = '0;
        handshake();

        // reset after four accepted elements drops the partial vector
        clear_src();
        for (int k = 0; k < 20; k++) src[0].push_back(3);
        req = 4'b0001;
        wait_gnt(0, 10); req = '0;
        acc_cnt[0] = 0;
        for (int n = 0; n < 40 && acc_cnt[0] < 4; n++) step();
        chk("t5_accepts", acc_cnt[0], 4);
        rst = 1'b1; #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 0);
        clear_src(); step(); rst = 1'b0;
        load_seq(0, 2, 0); req = 4'b0001;
        wait_gnt(0, 10); req = '0;
        wait_out(40);
        chk("t5_data", out_data, 18);
        handshake();

        // w[0] write in ACCUM and write to addr 12 are both ignored
        clear_src(); load_seq(3, 1, 1); req = 4'b1000;
        wait_gnt(3, 10); req = '0;
        cfg(0, 100);
        wait_out(40);
        chk("t6a_data", out_data, 45);
        chk("t6a_id", out_id, 3);
        handshake();
        cfg(12, 77);
        load_seq(3, 1, 1); req = 4'b1000;
        wait_gnt(3, 10); req = '0;
        wait_out(40);
        chk("t6b_data", out_data, 45);
        handshake();

        // cfg write in the same idle cycle as a grant: w[0]=10 -> 54
        clear_src(); step();
        load_seq(0, 1, 1);
        cfg_we = 1'b1; cfg_addr = 0; cfg_wdata = 10; req = 4'b0001;
        step();
        cfg_we = 1'b0; req = '0;
        chk("t7_gnt", gnt, 4'b0001);
        wait_out(40);
        chk("t7_data", out_data, 54);
        handshake();

        // randomized traffic, all checked by the model every cycle
        do_reset();
        gaps = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            req       = ($urandom_range(0, 3) == 0) ? NC'($urandom) : req;
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 4'($urandom_range(0, 15));
            cfg_wdata = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 6)) - 3;
            for (int i = 0; i < NC; i++)
                if (src[i].size() == 0)
                    for (int k = 0; k < 3; k++) src[i].push_back($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc_scheduler.md
FC_SCHEDULER -- requirements
Module: fc_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4, number of requesting cores sharing the FC engine.
REQ-002 Parameter VEC_LEN, default 9, elements per FC input vector.
REQ-003 Parameter DATA_W, default 32, signed data/weight/result width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_CORES  per-core request for one FC evaluation.
REQ-007 gnt  output  NUM_CORES  one-hot grant; all zero when idle.
REQ-008 in_valid  input  NUM_CORES  per-core element-valid strobe.
REQ-009 in_data  input  NUM_CORES*DATA_W  per-core signed element; core i occupies bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  output  NUM_CORES  per-core element accept; high only for the granted core in ACCUM.
REQ-011 cfg_we, cfg_addr[3:0], cfg_wdata[DATA_W-1:0]  input  weight/bias write port.
REQ-012 out_valid  output  1  result available.
REQ-013 out_data  output  DATA_W  ReLU'd signed result.
REQ-014 out_id  output  clog2(NUM_CORES)  index of the core that owns out_data.
REQ-015 out_ready  input  1  result consumer accept.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, OUT.
REQ-017 In IDLE with any req bit high, the block SHALL grant round-robin, searching from (last granted index + 1) mod NUM_CORES; after reset the search starts at core 0.
REQ-018 The IDLE->ACCUM transition SHALL assert gnt one cycle after req is sampled, clear acc to 0 and element counter cnt to 0.
REQ-019 In ACCUM, an element is accepted on any cycle where in_valid[g] && in_ready[g]; then acc <= acc + low DATA_W bits of (in_data[g] * w[cnt]), cnt <= cnt+1; arithmetic wraps mod 2^DATA_W.
REQ-020 in_valid from non-granted cores SHALL be ignored; gaps in in_valid SHALL stall without error.
REQ-021 On acceptance of element VEC_LEN-1, next cycle: state OUT, out_valid=1, out_data = relu(acc_final + bias), out_id = g; relu(x) = x if x>0 else 0.
REQ-022 out_valid, out_data, out_id SHALL hold stable until out_valid && out_ready.
REQ-023 On the out handshake cycle, the next cycle SHALL be IDLE with gnt=0 and out_valid=0; a new grant may follow one cycle later.
REQ-024 Grant SHALL be held until the result handshake even if req[g] drops mid-vector.
REQ-025 cfg writes SHALL take effect only in IDLE: addr 0..VEC_LEN-1 writes w[addr], addr VEC_LEN writes bias; other addresses and writes in ACCUM/OUT are ignored.
REQ-026 A cfg write and a new grant in the same IDLE cycle SHALL both occur; the first element uses the newly written weight.

Reset
REQ-027 rst SHALL immediately force: state IDLE, gnt=0, in_ready=0, out_valid=0, out_data=0, out_id=0, acc=0, cnt=0, round-robin pointer to core 0.
REQ-028 rst SHALL set every w[k]=1 and bias=0; a reset mid-vector discards the partial result with no output.

Structure
REQ-029 A shared package fc_pkg SHALL hold DATA_W, VEC_LEN, BIAS_ADDR (=VEC_LEN), and the FSM state enum.
REQ-030 The ReLU SHALL be the team's existing relu_unit instantiated on the biased sum; no other sub-module.

Verification
REQ-031 Defaults, core0 sends 1..9 back-to-back -> out_valid on the cycle after the 9th accept, out_data=45, out_id=0.
REQ-032 Write w[k]=-1 all k, bias=5, core1 sends all 1s -> out_data=0 (ReLU of -4), out_id=1.
REQ-033 req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0; no core granted twice consecutively.
REQ-034 out_ready low for 5 cycles after out_valid -> out_data/out_id stable, gnt held, no new grant until handshake.
REQ-035 rst pulse after 4 accepted elements -> outputs zero immediately, no out_valid; new vector of all 2s gives 18.
REQ-036 cfg_we to w[0] during ACCUM and to addr 12 in IDLE -> both ignored; result unchanged from defaults.
